// File: rtl/apu_pkg.sv
// Shared constants, types and the step-event decoder for the APU frame counter.
package apu_pkg;

  localparam int unsigned STEP_Q1     = 7457;
  localparam int unsigned STEP_Q2     = 14913;
  localparam int unsigned STEP_Q3     = 22371;
  localparam int unsigned STEP_IRQ    = 29828;
  localparam int unsigned STEP_4_END  = 29829;
  localparam int unsigned STEP_5_END  = 37281;

  localparam int unsigned DELAY_W     = 3;
  localparam int unsigned DELAY_EVEN  = 3;
  localparam int unsigned DELAY_ODD   = 4;

  typedef enum logic {
    MODE_4STEP = 1'b0,
    MODE_5STEP = 1'b1
  } frame_mode_t;

  typedef enum logic {
    IDLE    = 1'b0,
    PENDING = 1'b1
  } delay_state_t;

  typedef struct packed {
    logic quarter;
    logic half;
    logic irq;
    logic wrap;
  } frame_evt_t;

  // Events owed to the CPU cycle whose pre-increment count is cnt.
  function automatic frame_evt_t decode_step(input logic [31:0] cnt, input frame_mode_t m);
    frame_evt_t evt;
    evt = '0;
    case (cnt)
      STEP_Q1, STEP_Q3: evt.quarter = 1'b1;
      STEP_Q2: begin
        evt.quarter = 1'b1;
        evt.half    = 1'b1;
      end
      STEP_IRQ: evt.irq = (m == MODE_4STEP);
      STEP_4_END: begin
        if (m == MODE_4STEP) begin
          evt.quarter = 1'b1;
          evt.half    = 1'b1;
          evt.irq     = 1'b1;
          evt.wrap    = 1'b1;
        end
      end
      STEP_5_END: begin
        if (m == MODE_5STEP) begin
          evt.quarter = 1'b1;
          evt.half    = 1'b1;
          evt.wrap    = 1'b1;
        end
      end
      default: evt = '0;
    endcase
    return evt;
  endfunction

endpackage

// File: rtl/frame_write_delay.sv
// Delays a $4017 write by 3 or 4 CPU cycles (by phase) and holds the written mode.
// expire is high while the next CPU cycle without a new write ends the delay.
module frame_write_delay
  import apu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_clk_en,
  input  logic        start,
  input  logic        phase,
  input  frame_mode_t data,
  output logic        expire,
  output frame_mode_t mode
);

  delay_state_t         state;
  logic [DELAY_W-1:0]   delay;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      delay  <= '0;
      mode   <= MODE_4STEP;
      expire <= 1'b0;
    end else if (cpu_clk_en) begin
      if (start) begin
        // A new write always restarts the delay with its own data.
        state  <= PENDING;
        delay  <= phase ? DELAY_W'(DELAY_ODD) : DELAY_W'(DELAY_EVEN);
        mode   <= data;
        expire <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            expire <= 1'b0;
          end
          PENDING: begin
            if (delay == DELAY_W'(1)) begin
              state  <= IDLE;
              delay  <= '0;
              expire <= 1'b0;
            end else begin
              delay  <= delay - DELAY_W'(1);
              expire <= (delay == DELAY_W'(2));
            end
          end
          default: begin
            state  <= IDLE;
            expire <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: rtl/apu_frame_counter.sv
// APU frame sequencer: 4/5-step quarter/half clock ticks and the frame interrupt.
// Define APU_FRAME_IRQ_EN to build the frame interrupt logic; otherwise frame_irq is 0.
module apu_frame_counter
  import apu_pkg::*;
#(
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cpu_clk_en,
  input  logic       wr_en,
  input  logic [1:0] wr_data,
  input  logic       irq_clear,
  output logic       quarter_clk_en,
  output logic       half_clk_en,
  output logic       frame_irq,
  output logic       mode
);

  logic [CNT_WIDTH-1:0] count;
  logic                 phase;
  logic                 irq_inhibit;
  frame_mode_t          cur_mode;
  frame_mode_t          pending_mode;
  logic                 expire;

  logic                 write_c;
  logic                 fire_c;
  logic                 inhibit_next_c;
  frame_evt_t           evt_c;

  assign write_c        = cpu_clk_en & wr_en;
  assign fire_c         = cpu_clk_en & expire & ~wr_en;
  assign inhibit_next_c = write_c ? wr_data[0] : irq_inhibit;
  assign evt_c          = decode_step(32'(count), cur_mode);
  assign mode           = cur_mode;

  frame_write_delay u_delay (
    .clk        (clk),
    .rst        (rst),
    .cpu_clk_en (cpu_clk_en),
    .start      (write_c),
    .phase      (phase),
    .data       (frame_mode_t'(wr_data[1])),
    .expire     (expire),
    .mode       (pending_mode)
  );

  // Step counter, mode and tick outputs; expiry overrides the count decode.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count          <= '0;
      phase          <= 1'b0;
      irq_inhibit    <= 1'b0;
      cur_mode       <= MODE_4STEP;
      quarter_clk_en <= 1'b0;
      half_clk_en    <= 1'b0;
    end else begin
      quarter_clk_en <= 1'b0;
      half_clk_en    <= 1'b0;
      if (cpu_clk_en) begin
        phase <= ~phase;
        if (write_c) begin
          irq_inhibit <= wr_data[0];
        end
        if (fire_c) begin
          count          <= '0;
          cur_mode       <= pending_mode;
          quarter_clk_en <= (pending_mode == MODE_5STEP);
          half_clk_en    <= (pending_mode == MODE_5STEP);
        end else begin
          count          <= evt_c.wrap ? '0 : count + CNT_WIDTH'(1);
          quarter_clk_en <= evt_c.quarter;
          half_clk_en    <= evt_c.half;
        end
      end
    end
  end

`ifdef APU_FRAME_IRQ_EN
  logic irq_set_c;
  logic irq_drop_c;

  // Set beats both clear sources; a write with inhibit blocks the set itself.
  assign irq_set_c  = evt_c.irq & ~fire_c & ~inhibit_next_c;
  assign irq_drop_c = irq_clear | (write_c & wr_data[0]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_irq <= 1'b0;
    end else if (cpu_clk_en) begin
      if (irq_set_c) begin
        frame_irq <= 1'b1;
      end else if (irq_drop_c) begin
        frame_irq <= 1'b0;
      end
    end
  end
`else
  logic unused_irq_c;

  assign unused_irq_c = ^{irq_clear, evt_c.irq, inhibit_next_c};
  assign frame_irq    = 1'b0;
`endif

endmodule

// File: doc/apu_frame_counter.md
APU_FRAME_COUNTER -- requirements
Module: apu_frame_counter

Interface
REQ-001 SHALL have parameter CNT_WIDTH, default 16, the width of the CPU-cycle step counter.
REQ-002 SHALL have port clk, input, 1, system clock; one clock domain, all state on rising edge.
REQ-003 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-004 SHALL have port cpu_clk_en, input, 1, one-clk strobe per CPU cycle; all state advances only on it.
REQ-005 SHALL have port wr_en, input, 1, $4017 write strobe, valid only with cpu_clk_en.
REQ-006 SHALL have port wr_data, input, 2, {mode (bit1: 1 = 5-step), irq_inhibit (bit0)}.
REQ-007 SHALL have port irq_clear, input, 1, $4015 read strobe, valid only with cpu_clk_en.
REQ-008 SHALL have port quarter_clk_en, output, 1, one-clk envelope/linear-counter tick.
REQ-009 SHALL have port half_clk_en, output, 1, one-clk length-counter/sweep tick.
REQ-010 SHALL have port frame_irq, output, 1, frame interrupt flag, level.
REQ-011 SHALL have port mode, output, 1, current sequencer mode (0 = 4-step).

Function
REQ-012 SHALL keep a CNT_WIDTH-bit count; on each cpu_clk_en, count+1, or 0 at wrap.
REQ-013 SHALL decode events from the pre-increment count; the quarter/half outputs are registered and pulse for exactly one clk, on the clk after the qualifying cpu_clk_en.
REQ-014 4-step: quarter at 7457, 14913, 22371, 29829; half at 14913, 29829; wrap 29829->0.
REQ-015 5-step: quarter at 7457, 14913, 22371, 37281; half at 14913, 37281; no event at 29829; wrap 37281->0.
REQ-016 SHALL set frame_irq at counts 29828 and 29829 in 4-step mode when irq_inhibit=0; it is never set in 5-step mode.
REQ-017 SHALL clear frame_irq on irq_clear; a same-cycle set wins over clear.
REQ-018 SHALL keep a phase bit that toggles on every cpu_clk_en.
REQ-019 On a write, irq_inhibit SHALL update at the same edge; inhibit=1 SHALL clear frame_irq at that edge.
REQ-020 On a write, SHALL enter state PENDING with delay 3 CPU cycles if phase=0, else 4, and latch the pending mode.
REQ-021 FSM states IDLE and PENDING: PENDING decrements the delay per cpu_clk_en; at delay expiry SHALL return to IDLE, load count=0 and mode=pending mode.
REQ-022 At expiry with pending mode=1, SHALL emit quarter and half pulses immediately, on the next clk.
REQ-023 At expiry, a count-based event decoded in that same CPU cycle SHALL be suppressed.
REQ-024 A write during PENDING SHALL restart the delay (by current phase) with the new data.
REQ-025 Without cpu_clk_en, SHALL hold all state and drive quarter/half low.

Reset
REQ-026 While rst is high: count=0, mode=0, irq_inhibit=0, frame_irq=0, phase=0, FSM=IDLE, quarter_clk_en=0, half_clk_en=0.
REQ-027 Reset mid-PENDING SHALL discard the pending write.
REQ-028 First CPU cycle after reset release SHALL see count=0.

Configuration
REQ-029 Macro APU_FRAME_IRQ_EN: when defined, REQ-016/017/019 IRQ logic is present.
REQ-030 When APU_FRAME_IRQ_EN is undefined, frame_irq is constant 0, irq_inhibit is still stored, and irq_clear is ignored; sequencing is unchanged.

Structure
REQ-031 apu_pkg SHALL hold the step constants (7457, 14913, 22371, 29828, 29829, 37281) and enum frame_mode_t {MODE_4STEP, MODE_5STEP}.
REQ-032 The delay FSM SHALL be sub-module frame_write_delay: inputs start, phase, data; outputs expire, latched mode.

Verification
REQ-033 Reset, then 29830 CPU cycles in 4-step mode -> quarter pulses after counts 7457/14913/22371/29829, half pulses after 14913/29829, frame_irq=1 from 29828, count=0 after 29829.
REQ-034 Write 2'b10 at phase=0 -> mode=1 and count=0 after 3 CPU cycles, quarter+half pulse once at expiry, no frame_irq through 37281, next half at 37281.
REQ-035 frame_irq=1, then irq_clear at count 100 -> frame_irq=0; irq_clear at count 29829 -> frame_irq stays 1.
REQ-036 Write 2'b01 while frame_irq=1 -> frame_irq=0 on that edge; run to 29829 -> frame_irq stays 0.
REQ-037 Write at phase=1, second write 2 CPU cycles later -> single expiry, 3 or 4 cycles after the second write per its phase, with the second write's mode.
REQ-038 Assert rst during PENDING at count 500 -> all outputs 0, mode=0, no expiry pulse after release.
